// File: rtl/i2s_receiver.sv
// Standard I2S (Philips) receiver: oversamples bclk/lrclk/din in the clk_25mhz domain and
// presents stereo pairs on valid/ready. Optional frame_error output: define I2S_RX_FRAME_ERR_EN.
module i2s_receiver #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk_25mhz,
    input  logic                    reset,
    input  logic                    audio_bclk,
    input  logic                    audio_lrclk,
    input  logic                    audio_din,
    output logic [SAMPLE_WIDTH-1:0] sample_left,
    output logic [SAMPLE_WIDTH-1:0] sample_right,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    overrun
`ifdef I2S_RX_FRAME_ERR_EN
    ,
    output logic                    frame_error
`endif
);

    localparam int          CNT_W     = 6;
    localparam int          IDX_W     = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = 6'd63;
    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(SAMPLE_WIDTH);

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0]  bclk_sync, lrclk_sync, din_sync;
    logic                    bclk_prev;
    logic                    last_lr;
    logic                    bclk_cur, lr_cur, din_cur;
    logic                    tick, boundary;

    logic [SAMPLE_WIDTH-1:0] shift_reg;
    logic [SAMPLE_WIDTH-1:0] word_app;
    logic [SAMPLE_WIDTH-1:0] left_hold;
    logic [CNT_W-1:0]        bit_cnt;
    logic [CNT_W-1:0]        cnt_app;
    logic [IDX_W-1:0]        msb_idx;
    logic                    slot_full;

    logic                    left_done, pair_done, pair_load;

    assign bclk_cur = bclk_sync[SYNC_STAGES-1];
    assign lr_cur   = lrclk_sync[SYNC_STAGES-1];
    assign din_cur  = din_sync[SYNC_STAGES-1];
    assign tick     = bclk_cur & ~bclk_prev;
    assign boundary = tick & (lr_cur != last_lr);

    // Bits are written MSB-down, so a short slot leaves its unfilled LSBs at zero.
    assign slot_full = (bit_cnt >= WIDTH_CNT);
    assign msb_idx   = IDX_W'(SAMPLE_WIDTH - 1 - int'(bit_cnt));
    assign cnt_app   = (bit_cnt == CNT_MAX) ? CNT_MAX : bit_cnt + 6'd1;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        word_app = shift_reg;
        if (!slot_full) begin
            word_app[msb_idx] = din_cur;
        end
    end

    always_comb begin
        state_next = state;
        left_done  = 1'b0;
        pair_done  = 1'b0;
        if (boundary) begin
            case (state)
                SYNC_WAIT: if (!lr_cur) state_next = LEFT;
                LEFT: begin
                    if (lr_cur) begin
                        state_next = RIGHT;
                        left_done  = 1'b1;
                    end
                end
                RIGHT: begin
                    if (!lr_cur) begin
                        state_next = LEFT;
                        pair_done  = 1'b1;
                    end
                end
                default: state_next = SYNC_WAIT;
            endcase
        end
    end

    // A completed pair is only taken when the output slot is free or being emptied this cycle.
    assign pair_load = pair_done & (~sample_valid | sample_ready);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state <= SYNC_WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            bclk_sync  <= '0;
            lrclk_sync <= '0;
            din_sync   <= '0;
            bclk_prev  <= 1'b0;
            last_lr    <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], audio_bclk};
            lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], audio_lrclk};
            din_sync   <= {din_sync[SYNC_STAGES-2:0], audio_din};
            bclk_prev  <= bclk_cur;
            if (tick) begin
                last_lr <= lr_cur;
            end
        end
    end

    // NOTE: the holding and output registers are plain flops, not a memory, so all take the reset.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            left_hold    <= '0;
            sample_left  <= '0;
            sample_right <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (tick) begin
                if (boundary || state == SYNC_WAIT) begin
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                end else begin
                    shift_reg <= word_app;
                    bit_cnt   <= cnt_app;
                end
            end

            if (left_done) begin
                left_hold <= word_app;
            end

            if (pair_load) begin
                sample_left  <= left_hold;
                sample_right <= word_app;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            if (pair_done && !pair_load) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef I2S_RX_FRAME_ERR_EN
    logic [CNT_W-1:0] left_cnt;
    logic             slot_err;

    // Slot lengths must match, cover the kept width, and not run into counter saturation.
    assign slot_err = (left_cnt != cnt_app)
                    | (left_cnt < WIDTH_CNT) | (cnt_app < WIDTH_CNT)
                    | (left_cnt == CNT_MAX)  | (cnt_app == CNT_MAX);

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            left_cnt    <= '0;
            frame_error <= 1'b0;
        end else begin
            if (left_done) begin
                left_cnt <= cnt_app;
            end
            frame_error <= pair_done & slot_err;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: drives an I2S stream at clk/24 and scores the
// delivered pairs against a queue of expected pairs built from the transmitted words.
module tb_i2s_receiver;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic         fe;
    } pair_t;

    logic         clk_25mhz;
    logic         reset;
    logic         audio_bclk;
    logic         audio_lrclk;
    logic         audio_din;
    logic [W-1:0] sample_left;
    logic [W-1:0] sample_right;
    logic         sample_valid;
    logic         sample_ready;
    logic         overrun;
`ifdef I2S_RX_FRAME_ERR_EN
    logic         frame_error;
    logic         fe_seen;
`endif

    int    checks       = 0;
    int    failures     = 0;
    int    valid_cycles = 0;
    logic  prev_valid   = 1'b0;
    logic  pend_bit     = 1'b0;
    pair_t sb_q[$];

    i2s_receiver #(
        .SAMPLE_WIDTH (W),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_25mhz    (clk_25mhz),
        .reset        (reset),
        .audio_bclk   (audio_bclk),
        .audio_lrclk  (audio_lrclk),
        .audio_din    (audio_din),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
`ifdef I2S_RX_FRAME_ERR_EN
        ,
        .frame_error  (frame_error)
`endif
    );

    initial clk_25mhz = 1'b0;
    always #20 clk_25mhz = ~clk_25mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_word(input logic [31:0] w, input int len);
        logic [31:0] t;
        if (len >= W) t = w >> (len - W);
        else          t = w << (W - len);
        return t[W-1:0];
    endfunction

    function automatic pair_t make_pair(input logic [31:0] l, input int ll,
                                        input logic [31:0] r, input int rl);
        pair_t p;
        int    cl, cr;
        cl   = (ll > 63) ? 63 : ll;
        cr   = (rl > 63) ? 63 : rl;
        p.l  = exp_word(l, ll);
        p.r  = exp_word(r, rl);
        p.fe = (cl != cr) || (cl < W) || (cr < W) || (cl == 63) || (cr == 63);
        return p;
    endfunction

    // One bclk period; din carries the previous data bit (I2S one-bit delay).
    task automatic bclk_cycle(input logic lr, input logic d);
        audio_lrclk = lr;
        audio_din   = pend_bit;
        pend_bit    = d;
        audio_bclk  = 1'b0;
        #480;
        audio_bclk  = 1'b1;
        #480;
    endtask

    task automatic send_slot(input logic lr, input logic [31:0] w, input int len);
        for (int k = len - 1; k >= 0; k--) bclk_cycle(lr, w[k]);
    endtask

    task automatic send_frame(input logic [31:0] l, input int ll,
                              input logic [31:0] r, input int rl, input bit push);
        if (push) sb_q.push_back(make_pair(l, ll, r, rl));
        send_slot(1'b0, l, ll);
        send_slot(1'b1, r, rl);
    endtask

    // Scoreboard side: every handshake pops one expected pair.
    always @(negedge clk_25mhz) begin
        if (!reset) begin
            if (sample_valid) valid_cycles++;
`ifdef I2S_RX_FRAME_ERR_EN
            if (sample_valid && !prev_valid) fe_seen = frame_error;
`endif
            if (sample_valid && sample_ready) begin
                check("pair_expected", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    pair_t e;
                    e = sb_q.pop_front();
                    check("pair_left", 32'(sample_left), 32'(e.l));
                    check("pair_right", 32'(sample_right), 32'(e.r));
`ifdef I2S_RX_FRAME_ERR_EN
                    check("pair_frame_error", 32'(fe_seen), 32'(e.fe));
`endif
                end
            end
        end
        prev_valid = sample_valid;
    end

    initial begin
        logic [15:0] part_l;
        part_l       = 16'h5A5A;
        reset        = 1'b1;
        audio_bclk   = 1'b0;
        audio_lrclk  = 1'b1;
        audio_din    = 1'b0;
        sample_ready = 1'b1;
        repeat (4) @(posedge clk_25mhz);
        #1 reset = 1'b0;

        check("rst_left", 32'(sample_left), 32'd0);
        check("rst_right", 32'(sample_right), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // Stream joins mid right slot; this partial frame must produce nothing.
        repeat (5) bclk_cycle(1'b1, 1'b1);

        send_frame(32'h8000, 16, 32'h7FFF, 16, 1'b1);
        send_frame(32'h8000, 16, 32'h7FFF, 16, 1'b1);
        send_frame(32'h1234_5678, 32, 32'hFEDC_BA98, 32, 1'b1);
        check("valid_pulse_cycles", 32'(valid_cycles), 32'd2);
        check("overrun_free_run", 32'(overrun), 32'd0);

        send_frame(32'h0ABC, 12, 32'h0123, 12, 1'b1);

        // Back-pressure: P1 is held, P2 and P3 are dropped.
        send_frame(32'h1111, 16, 32'h2222, 16, 1'b1);
        sample_ready = 1'b0;
        send_frame(32'h3333, 16, 32'h4444, 16, 1'b0);
        check("hold_valid", 32'(sample_valid), 32'd1);
        check("hold_left_p2", 32'(sample_left), 32'h1111);
        check("overrun_after_first", 32'(overrun), 32'd0);
        send_frame(32'h5555, 16, 32'h6666, 16, 1'b0);
        check("overrun_after_second", 32'(overrun), 32'd1);
        check("hold_left_p3", 32'(sample_left), 32'h1111);
        check("hold_right_p3", 32'(sample_right), 32'h2222);

        sb_q.push_back(make_pair(32'h7777, 16, 32'h8888, 16));
        send_slot(1'b0, 32'h7777, 16);
        @(posedge clk_25mhz);
        #1 sample_ready = 1'b1;
        @(posedge clk_25mhz);
        #1 sample_ready = 1'b0;
        check("valid_after_accept", 32'(sample_valid), 32'd0);
        send_slot(1'b1, 32'h8888, 16);
        sample_ready = 1'b1;

        // Reset in the middle of a left word; the partial frame is discarded.
        for (int k = 15; k >= 8; k--) bclk_cycle(1'b0, part_l[k]);
        @(posedge clk_25mhz);
        #1 reset = 1'b1;
        @(posedge clk_25mhz);
        #1 reset = 1'b0;
        check("midrst_left", 32'(sample_left), 32'd0);
        check("midrst_right", 32'(sample_right), 32'd0);
        check("midrst_valid", 32'(sample_valid), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        for (int k = 7; k >= 0; k--) bclk_cycle(1'b0, part_l[k]);
        send_slot(1'b1, 32'h3C3C, 16);

        send_frame(32'h0F0F, 16, 32'hF0F0, 16, 1'b1);
        bclk_cycle(1'b0, 1'b0);
        repeat (40) @(posedge clk_25mhz);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("overrun_final", 32'(overrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
